// File: rtl/alu_pkg.sv
// Shared definitions for the iterative ALU.
//   op_e    : 3-bit opcode encoding presented on iter_alu.op
//   state_e : control FSM state encoding
//   CNT_W   : width of the shared MUL/SHIFT iteration counter; sized to hold
//             the largest legal WIDTH (64) so one package serves every build.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'd0,
    OP_OR  = 3'd1,
    OP_ADD = 3'd2,
    OP_MUL = 3'd3,
    OP_SLL = 3'd4,
    OP_SRL = 3'd5,
    OP_SUB = 3'd6,
    OP_SLT = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MUL   = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam int CNT_W = 7;

endpackage

// File: rtl/addsub_w.sv
// Combinational WIDTH-bit adder/subtractor.
//   a, b     : operands
//   sub      : 0 -> a+b, 1 -> a+~b+1
//   sum      : result modulo 2^WIDTH
//   cout     : carry out of the MSB
//   overflow : carry into the MSB xor carry out of the MSB
module addsub_w #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] low;   // low[WIDTH-1] is the carry into the MSB
  logic             c_msb;
  logic             s_msb;

  // The low WIDTH-1 bits are added separately so the carry into the MSB is
  // directly visible for the signed-overflow flag.
  always_comb begin
    b_eff = sub ? ~b : b;
    low   = {1'b0, a[WIDTH-2:0]} + {1'b0, b_eff[WIDTH-2:0]} + {{(WIDTH-1){1'b0}}, sub};
    c_msb = low[WIDTH-1];
    s_msb = a[WIDTH-1] ^ b_eff[WIDTH-1] ^ c_msb;
    cout  = (a[WIDTH-1] & b_eff[WIDTH-1]) | (c_msb & (a[WIDTH-1] ^ b_eff[WIDTH-1]));
    overflow = c_msb ^ cout;
    sum   = {s_msb, low[WIDTH-2:0]};
  end

endmodule

// File: rtl/iter_alu.sv
// Iterative ALU: single-cycle logic/arithmetic ops, multi-cycle shift-add
// multiply and bit-serial shifts, with a valid/ready handshake on both sides.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid, in_ready  : operation handshake (in_ready high only in IDLE)
//   a, b, op            : operands and opcode (see alu_pkg::op_e)
//   out_valid, out_ready: result handshake (out_valid high only in DONE)
//   out                 : result
//   zero, overflow, cout: status flags belonging to out
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// 1; the producer holds its data stable while valid=1 and ready=0, and the
// result side holds out/flags unchanged in DONE until out_ready is seen.
module iter_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             overflow,
  output logic             cout
);

  state_e           state_q, state_n;
  op_e              op_q, op_n;
  logic [SHW-1:0]   shamt_q, shamt_n;
  logic [CNT_W-1:0] cnt_q, cnt_n, cnt_inc;
  logic [WIDTH-1:0] mcand_q, mcand_n;
  // sr holds the multiplier (and the growing low product) for MUL, or the
  // operand being shifted for SLL/SRL.
  logic [WIDTH-1:0] sr_q, sr_n;
  logic [WIDTH-1:0] hi_q, hi_n;
  logic [WIDTH-1:0] out_q, out_n;
  logic             ov_q, ov_n;
  logic             co_q, co_n;

  // Single-cycle datapath, fed straight from the input ports.
  op_e              op_in;
  logic [WIDTH-1:0] as_sum;
  logic             as_cout, as_ov;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ov, alu_co;

  // One shift-add multiply step.
  logic [WIDTH:0]   hi_add;
  logic [WIDTH-1:0] mul_hi, mul_lo;
  logic [WIDTH-1:0] sh_next;

  assign op_in = op_e'(op);

  addsub_w #(.WIDTH(WIDTH)) u_addsub (
    .a        (a),
    .b        (b),
    .sub      (op_in != OP_ADD),
    .sum      (as_sum),
    .cout     (as_cout),
    .overflow (as_ov)
  );

  always_comb begin
    alu_res = '0;
    alu_ov  = 1'b0;
    alu_co  = 1'b0;
    case (op_in)
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_ADD, OP_SUB: begin
        alu_res = as_sum;
        alu_ov  = as_ov;
        alu_co  = as_cout;
      end
      OP_SLT: begin
        // Sign of the difference corrected by overflow gives signed a<b.
        alu_res = {{(WIDTH-1){1'b0}}, as_sum[WIDTH-1] ^ as_ov};
        alu_ov  = as_ov;
        alu_co  = as_cout;
      end
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    hi_add  = {1'b0, hi_q} + {1'b0, (sr_q[0] ? mcand_q : {WIDTH{1'b0}})};
    mul_hi  = hi_add[WIDTH:1];
    mul_lo  = {hi_add[0], sr_q[WIDTH-1:1]};
    sh_next = (op_q == OP_SRL) ? (sr_q >> 1) : (sr_q << 1);
    cnt_inc = cnt_q + 1'b1;
  end

  always_comb begin
    state_n = state_q;
    op_n    = op_q;
    shamt_n = shamt_q;
    cnt_n   = cnt_q;
    mcand_n = mcand_q;
    sr_n    = sr_q;
    hi_n    = hi_q;
    out_n   = out_q;
    ov_n    = ov_q;
    co_n    = co_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_n    = op_in;
          shamt_n = b[SHW-1:0];
          cnt_n   = '0;
          case (op_in)
            OP_MUL: begin
              mcand_n = a;
              sr_n    = b;
              hi_n    = '0;
              state_n = S_MUL;
            end
            OP_SLL, OP_SRL: begin
              sr_n = a;
              if (b[SHW-1:0] == '0) begin
                out_n   = a;
                ov_n    = 1'b0;
                co_n    = 1'b0;
                state_n = S_DONE;
              end else begin
                state_n = S_SHIFT;
              end
            end
            default: begin
              out_n   = alu_res;
              ov_n    = alu_ov;
              co_n    = alu_co;
              state_n = S_DONE;
            end
          endcase
        end
      end
      S_MUL: begin
        hi_n  = mul_hi;
        sr_n  = mul_lo;
        cnt_n = cnt_inc;
        if (cnt_inc == CNT_W'(WIDTH)) begin
          out_n   = mul_lo;
          ov_n    = |mul_hi;
          co_n    = 1'b0;
          state_n = S_DONE;
        end
      end
      S_SHIFT: begin
        sr_n  = sh_next;
        cnt_n = cnt_inc;
        if (cnt_inc == CNT_W'(shamt_q)) begin
          out_n   = sh_next;
          ov_n    = 1'b0;
          co_n    = 1'b0;
          state_n = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_AND;
      shamt_q <= '0;
      cnt_q   <= '0;
      mcand_q <= '0;
      sr_q    <= '0;
      hi_q    <= '0;
      out_q   <= '0;
      ov_q    <= 1'b0;
      co_q    <= 1'b0;
    end else begin
      state_q <= state_n;
      op_q    <= op_n;
      shamt_q <= shamt_n;
      cnt_q   <= cnt_n;
      mcand_q <= mcand_n;
      sr_q    <= sr_n;
      hi_q    <= hi_n;
      out_q   <= out_n;
      ov_q    <= ov_n;
      co_q    <= co_n;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out       = out_q;
  assign zero      = (out_q == '0);
  assign overflow  = ov_q;
  assign cout      = co_q;

endmodule

// File: tb/tb_iter_alu.sv
// Directed testbench for iter_alu (WIDTH=32). Expected values are hand-computed.
module tb_iter_alu;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic         zero;
  logic         overflow;
  logic         cout;

  int checks = 0;
  int errors = 0;

  iter_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .zero      (zero),
    .overflow  (overflow),
    .cout      (cout)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit
  // after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Issue one op from IDLE, wait for out_valid (bounded), check latency,
  // result, flags and that in_ready stayed low while busy, then consume it.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input int exp_lat,
                        input logic [W-1:0] exp_out, input logic exp_z,
                        input logic exp_ov, input logic exp_co);
    int   lat;
    logic rdy_seen;
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    op = o;
    a  = av;
    b  = bv;
    tick();
    in_valid = 1'b0;
    a  = $urandom();
    b  = $urandom();
    lat = 1;
    rdy_seen = 1'b0;
    while (!out_valid && lat < 200) begin
      rdy_seen = rdy_seen | in_ready;
      tick();
      lat++;
    end
    rdy_seen = rdy_seen | in_ready;
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_busy_ready"}, 64'(rdy_seen), 64'd0);
    chk({tag, "_out"}, 64'(out), 64'(exp_out));
    chk({tag, "_flags"}, {61'd0, zero, overflow, cout}, {61'd0, exp_z, exp_ov, exp_co});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_back_idle"}, {62'd0, out_valid, in_ready}, {62'd0, 1'b0, 1'b1});
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int seen;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    op = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out", 64'(out), 64'd0);
    chk("rst_flags", {61'd0, zero, overflow, cout}, {61'd0, 1'b1, 1'b0, 1'b0});

    // Single-cycle ops                     op    a             b             lat out           z     ov    co
    run_op("add_ovf",  3'd2, 32'h7FFF_FFFF, 32'h0000_0001, 1, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    run_op("add_wrap", 3'd2, 32'hFFFF_FFFF, 32'h0000_0001, 1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    run_op("sub_eq",   3'd6, 32'h0000_0005, 32'h0000_0005, 1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    run_op("slt_neg",  3'd7, 32'hFFFF_FFCE, 32'hFFFF_FFCF, 1, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    run_op("slt_ovf",  3'd7, 32'h8000_0000, 32'h0000_0001, 1, 32'h0000_0001, 1'b0, 1'b1, 1'b1);
    run_op("slt_ge",   3'd7, 32'h0000_0009, 32'h0000_0002, 1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    run_op("and",      3'd0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1, 32'h00F0_00F0, 1'b0, 1'b0, 1'b0);
    run_op("or",       3'd1, 32'h1234_0000, 32'h0000_5678, 1, 32'h1234_5678, 1'b0, 1'b0, 1'b0);

    // Multiply
    run_op("mul_big",  3'd3, 32'h0001_0000, 32'h0001_0000, 33, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
    run_op("mul_3x7",  3'd3, 32'h0000_0003, 32'h0000_0007, 33, 32'h0000_0015, 1'b0, 1'b0, 1'b0);
    run_op("mul_wrap", 3'd3, 32'hFFFF_FFFF, 32'h0000_0002, 33, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0);

    // Shifts (upper bits of b beyond the shift amount are ignored)
    run_op("sll_31",   3'd4, 32'h0000_0001, 32'h0000_001F, 32, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
    run_op("srl_0",    3'd5, 32'hDEAD_BEEF, 32'h0000_0000, 1,  32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
    run_op("srl_4",    3'd5, 32'h8000_0000, 32'hFFFF_FFE4, 5,  32'h0800_0000, 1'b0, 1'b0, 1'b0);
    run_op("sll_out",  3'd4, 32'h0000_0003, 32'h0000_001F, 32, 32'h8000_0000, 1'b0, 1'b0, 1'b0);

    // DONE hold: result stays put while out_ready=0, in_valid is ignored.
    in_valid = 1'b1;
    op = 3'd2;
    a = 32'hFFFF_FFFF;
    b = 32'h0000_0001;
    tick();
    op = 3'd1;
    a = 32'hAAAA_AAAA;
    b = 32'h5555_5555;
    for (int i = 0; i < 10; i++) begin
      chk("hold_valid", {62'd0, out_valid, in_ready}, {62'd0, 1'b1, 1'b0});
      chk("hold_out", 64'(out), 64'd0);
      chk("hold_flags", {61'd0, zero, overflow, cout}, {61'd0, 1'b1, 1'b0, 1'b1});
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk("release_idle", {62'd0, out_valid, in_ready}, {62'd0, 1'b0, 1'b1});
    tick();
    chk("release_no_accept", 64'(out_valid), 64'd0);

    // Reset in the middle of a multiply.
    in_valid = 1'b1;
    op = 3'd3;
    a = 32'h0000_0003;
    b = 32'h0000_0007;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_state", {62'd0, out_valid, in_ready}, {62'd0, 1'b0, 1'b1});
    chk("midrst_out", 64'(out), 64'd0);
    chk("midrst_flags", {61'd0, zero, overflow, cout}, {61'd0, 1'b1, 1'b0, 1'b0});
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen++;
      tick();
    end
    chk("midrst_no_valid", 64'(seen), 64'd0);
    run_op("add_after_rst", 3'd2, 32'h0000_0002, 32'h0000_0003, 1, 32'h0000_0005, 1'b0, 1'b0, 1'b0);

    // Reset wins over a simultaneous in_valid.
    rst = 1'b1;
    in_valid = 1'b1;
    op = 3'd2;
    a = 32'h0000_0010;
    b = 32'h0000_0020;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    chk("rst_prio_state", {62'd0, out_valid, in_ready}, {62'd0, 1'b0, 1'b1});
    tick();
    chk("rst_prio_no_result", 64'(out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time limit so the bench can never hang.
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
